// File: rtl/vedic_pkg.sv
// Shared types and constants for the sequential 32x32 vedic multiplier controller.
package vedic_pkg;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSTEPS = (WIDTH / SLICE) * (WIDTH / SLICE);
  localparam int STEP_W = 4;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/vedic8x8.sv
// Combinational vedic multipliers: 2x2 from half adders, 4x4 and 8x8 from
// four half-width vedic products combined with their crosswise terms.
module vedic_ha (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module vedic2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic w_c1;

  assign p[0] = a[0] & b[0];

  vedic_ha u_ha0 (
    .i_a (a[1] & b[0]),
    .i_b (a[0] & b[1]),
    .o_s (p[1]),
    .o_c (w_c1)
  );

  vedic_ha u_ha1 (
    .i_a (a[1] & b[1]),
    .i_b (w_c1),
    .o_s (p[2]),
    .o_c (p[3])
  );
endmodule

module vedic4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] w_q0, w_q1, w_q2, w_q3;

  vedic2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(w_q0));
  vedic2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(w_q1));
  vedic2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(w_q2));
  vedic2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(w_q3));

  // Vertical terms concatenate; crosswise terms land at the middle weight.
  assign p = {w_q3, w_q0} + {2'b00, w_q1, 2'b00} + {2'b00, w_q2, 2'b00};
endmodule

module vedic8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [7:0] w_q0, w_q1, w_q2, w_q3;

  vedic4x4 u_ll (.a(a[3:0]), .b(b[3:0]), .p(w_q0));
  vedic4x4 u_hl (.a(a[7:4]), .b(b[3:0]), .p(w_q1));
  vedic4x4 u_lh (.a(a[3:0]), .b(b[7:4]), .p(w_q2));
  vedic4x4 u_hh (.a(a[7:4]), .b(b[7:4]), .p(w_q3));

  assign p = {w_q3, w_q0} + {4'b0000, w_q1, 4'b0000} + {4'b0000, w_q2, 4'b0000};
endmodule

// File: rtl/vedic_seq_mul32_ctrl.sv
// 32x32 unsigned multiplier that reuses one vedic8x8 slice over 16 steps,
// accumulating partial products into a 64-bit result behind valid/ready ports.
module vedic_seq_mul32_ctrl
  import vedic_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] Prod,
  output logic        busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a producer holds valid and its data stable until that edge.

  state_t            r_state;
  state_t            w_state_nxt;
  logic [STEP_W-1:0] r_idx;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [63:0]       r_acc;
  logic [63:0]       r_prod;

  logic [1:0]        w_i;
  logic [1:0]        w_j;
  logic [7:0]        w_a_sl;
  logic [7:0]        w_b_sl;
  logic [15:0]       w_pp16;
  logic [2:0]        w_wsum;
  logic [5:0]        w_shamt;
  logic [63:0]       w_pp_shift;
  logic [63:0]       w_acc_next;
  logic              w_accept;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (r_idx == LAST_STEP) w_state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // No bypass into a new job: the next accept waits for IDLE.
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = (r_state == IDLE) && in_valid;

  // idx[1:0] walks the A byte, idx[3:2] the B byte; weight is 8*(i+j).
  assign w_i        = r_idx[1:0];
  assign w_j        = r_idx[3:2];
  assign w_a_sl     = r_a[{w_i, 3'b000} +: 8];
  assign w_b_sl     = r_b[{w_j, 3'b000} +: 8];
  assign w_wsum     = {1'b0, w_i} + {1'b0, w_j};
  assign w_shamt    = {w_wsum, 3'b000};
  assign w_pp_shift = {48'd0, w_pp16} << w_shamt;
  assign w_acc_next = r_acc + w_pp_shift;

  vedic8x8 u_slice (
    .a (w_a_sl),
    .b (w_b_sl),
    .p (w_pp16)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_acc  <= '0;
      r_prod <= '0;
      r_a    <= '0;
      r_b    <= '0;
    end else if (w_accept) begin
      r_a   <= A;
      r_b   <= B;
      r_acc <= '0;
      r_idx <= '0;
    end else if (r_state == CALC) begin
      r_acc <= w_acc_next;
      r_idx <= r_idx + 4'd1;
      if (r_idx == LAST_STEP) r_prod <= w_acc_next;
    end
  end

  assign Prod = r_prod;

endmodule

// File: doc/vedic_seq_mul32_ctrl.md
Name: vedic_seq_mul32_ctrl

Overview:
Multi-cycle controller that computes a 32x32 unsigned product by time-multiplexing one combinational vedic8x8 slice multiplier over 16 partial-product steps. The 64-bit result is accumulated internally. Valid/ready handshakes on input and output let the block sit between an operand source and a result consumer in place of a full-area vedic32x32 array.

Parameters:
WIDTH, 32, operand width (fixed at 32 for this revision)
SLICE, 8, slice multiplier width; step count = (WIDTH/SLICE)^2 = 16

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair A/B valid
in_ready  output  1  block can accept operands
A  input  32  multiplicand, unsigned
B  input  32  multiplier, unsigned
out_valid  output  1  Prod holds a completed result
out_ready  input  1  consumer accepts result
Prod  output  64  product A*B
busy  output  1  high in CALC or DONE

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, Prod=0, out_valid=0, busy=0, step counter=0, accumulator=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation: the current job is aborted. No out_valid is produced for it. Operand registers are don't-care.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, register A and B, clear the accumulator, set idx=0, go to CALC.
  - CALC: in_ready=0, busy=1. Each cycle, i=idx[1:0] and j=idx[3:2].
    - Feed a_sl=A_r[8i+:8] and b_sl=B_r[8j+:8] to vedic8x8.
    - Update acc <= acc + (pp16 << 8*(i+j)).
    - Increment idx. At idx=15, load Prod with the final sum and go to DONE.
  - DONE: out_valid=1, busy=1, in_ready=0. Prod is held stable. On out_ready, go to IDLE with out_valid=0.
- Latency: operands accepted at edge T; CALC occupies edges T+1..T+16; out_valid is high after edge T+16. Minimum issue interval is 18 cycles (accept, 16 CALC, DONE with immediate out_ready).
- No bypass: in_valid while in DONE is not accepted, even with out_ready=1 in the same cycle. The next accept happens in IDLE one cycle later.
- A and B are sampled only at the accept edge. Input changes during CALC have no effect.
- Arithmetic: the accumulator is 64 bits wide. The maximum product 0xFFFFFFFE00000001 fits, so no overflow or saturation logic is needed.
- Prod keeps its last value after the output handshake until the next job completes. It is only written at the CALC->DONE transition and on reset.
- out_valid, once high, stays high until out_ready (standard valid/ready hold rule).
- in_valid and out_ready are don't-care outside their respective states.

Decomposition:
- Shared package vedic_pkg:
  - state enum {IDLE, CALC, DONE}
  - constants WIDTH=32, SLICE=8, NSTEPS=16
  - step-counter width 4
- Sub-module: the existing vedic8x8, instantiated once as the shared combinational slice multiplier (built from vedic4x4/vedic2x2 and HA/adder cells).
- FSM, counter, slice mux and accumulator all live in this block.

Test Plan:
- A=0xFFFFFFFF, B=0xFFFFFFFF, out_ready=1 -> out_valid exactly 16 cycles after the accept edge. Prod=0xFFFFFFFE00000001, held for one cycle, then IDLE.
- A=0xDEADBEEF, B=0x00000001, then A=0x00010000, B=0x00010000 back-to-back -> Prod=0x00000000DEADBEEF, then 0x0000000100000000. in_ready is low in every cycle from accept through DONE.
- A=0x80000000, B=0x00000002, out_ready held low for 10 cycles -> out_valid and Prod=0x0000000100000000 remain stable all 10 cycles. in_valid asserted during DONE is ignored. Completes after out_ready rises.
- Change A/B every cycle during CALC after accepting A=0x00000003, B=0x00000005 -> Prod=0x000000000000000F.
- rst pulsed at CALC step 7 of A=0x12345678, B=0x11111111 -> next cycle: IDLE, out_valid=0, Prod=0, busy=0, in_ready=1. A new job with A=7, B=6 then yields Prod=42.
- A=0, B=0xFFFFFFFF and A=0xFFFFFFFF, B=0 -> Prod=0 for both. Also a 200-pair random sweep checked against a reference multiply.
